// File: rtl/benes_pkg.sv
// Shared definitions for the Benes switch column: 2x2 cell modes and field width.
package benes_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    BAR      = 2'b00,
    CROSS    = 2'b01,
    BCAST_UP = 2'b10,
    BCAST_LO = 2'b11
  } cell_mode_t;

endpackage

// File: rtl/benes_sw_cell.sv
// One registered 2x2 switch cell: routes a port pair by mode, zeroes data on
// invalid outputs, and holds its outputs while stalled.
module benes_sw_cell
  import benes_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [MODE_W-1:0] mode,
  input  logic              stall,
  input  logic [1:0]        in_valid,
  input  logic [DATA_W-1:0] in_data0,
  input  logic [DATA_W-1:0] in_data1,
  output logic [1:0]        out_valid,
  output logic [DATA_W-1:0] out_data0,
  output logic [DATA_W-1:0] out_data1
);

  cell_mode_t        cell_mode;
  logic              sel0;
  logic              sel1;
  logic [1:0]        nxt_valid;
  logic [DATA_W-1:0] nxt_data0;
  logic [DATA_W-1:0] nxt_data1;

  assign cell_mode = cell_mode_t'(mode);

  // sel0/sel1 name the input (0 = upper, 1 = lower) that feeds each output.
  always_comb begin
    sel0 = 1'b0;
    sel1 = 1'b1;
    case (cell_mode)
      BAR:      begin sel0 = 1'b0; sel1 = 1'b1; end
      CROSS:    begin sel0 = 1'b1; sel1 = 1'b0; end
      BCAST_UP: begin sel0 = 1'b0; sel1 = 1'b0; end
      BCAST_LO: begin sel0 = 1'b1; sel1 = 1'b1; end
      default:  begin sel0 = 1'b0; sel1 = 1'b1; end
    endcase
  end

  always_comb begin
    nxt_valid[0] = in_valid[sel0];
    nxt_valid[1] = in_valid[sel1];
    nxt_data0    = '0;
    nxt_data1    = '0;
    if (nxt_valid[0]) nxt_data0 = sel0 ? in_data1 : in_data0;
    if (nxt_valid[1]) nxt_data1 = sel1 ? in_data1 : in_data0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= '0;
      out_data0 <= '0;
      out_data1 <= '0;
    end else if (!stall) begin
      out_valid <= nxt_valid;
      out_data0 <= nxt_data0;
      out_data1 <= nxt_data1;
    end
  end

endmodule

// File: rtl/benes_switch_column.sv
// One column of a Benes network: N_PORTS/2 registered 2x2 cells plus a shadowed
// configuration that is only applied on idle, unstalled cycles.
module benes_switch_column
  import benes_pkg::*;
#(
  parameter int DATA_W  = 4,
  parameter int N_PORTS = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_PORTS-1:0]        i_valid,
  input  logic [N_PORTS*DATA_W-1:0] i_data,
  input  logic                      i_stall,
  output logic [N_PORTS-1:0]        o_valid,
  output logic [N_PORTS*DATA_W-1:0] o_data,
  input  logic                      cfg_wr,
  input  logic [N_PORTS-1:0]        cfg_data,
  output logic                      cfg_pending,
  output logic [N_PORTS-1:0]        o_cfg,
  output logic [7:0]                cfg_apply_cnt
);

  localparam int N_CELLS = N_PORTS / 2;

  // Flow control: there is no ready; i_stall=1 freezes every output register
  // and the upstream keeps its valid/data steady until the stall drops.
  logic [N_PORTS-1:0] shadow;
  logic               apply;

  // Switching only when no port carries data keeps packets on one configuration.
  assign apply = cfg_pending && (i_valid == '0) && !i_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow        <= '0;
      cfg_pending   <= 1'b0;
      o_cfg         <= '0;
      cfg_apply_cnt <= '0;
    end else begin
      if (cfg_wr) shadow <= cfg_data;
      if (cfg_wr) cfg_pending <= 1'b1;
      else if (apply) cfg_pending <= 1'b0;
      if (apply) begin
        o_cfg         <= shadow;
        cfg_apply_cnt <= cfg_apply_cnt + 8'd1;
      end
    end
  end

  for (genvar k = 0; k < N_CELLS; k++) begin : g_cell
    benes_sw_cell #(
      .DATA_W(DATA_W)
    ) u_cell (
      .clk      (clk),
      .rst_n    (rst_n),
      .mode     (o_cfg[k*MODE_W +: MODE_W]),
      .stall    (i_stall),
      .in_valid (i_valid[2*k +: 2]),
      .in_data0 (i_data[(2*k)*DATA_W +: DATA_W]),
      .in_data1 (i_data[(2*k+1)*DATA_W +: DATA_W]),
      .out_valid(o_valid[2*k +: 2]),
      .out_data0(o_data[(2*k)*DATA_W +: DATA_W]),
      .out_data1(o_data[(2*k+1)*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_benes_switch_column.sv
// Self-checking bench for benes_switch_column: directed scenarios plus random
// traffic, compared every cycle against a port-routing model.
module tb_benes_switch_column;

  localparam int DATA_W  = 4;
  localparam int N_PORTS = 8;

  logic                      clk;
  logic                      rst_n;
  logic [N_PORTS-1:0]        i_valid;
  logic [N_PORTS*DATA_W-1:0] i_data;
  logic                      i_stall;
  logic [N_PORTS-1:0]        o_valid;
  logic [N_PORTS*DATA_W-1:0] o_data;
  logic                      cfg_wr;
  logic [N_PORTS-1:0]        cfg_data;
  logic                      cfg_pending;
  logic [N_PORTS-1:0]        o_cfg;
  logic [7:0]                cfg_apply_cnt;

  benes_switch_column #(
    .DATA_W (DATA_W),
    .N_PORTS(N_PORTS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_valid      (i_valid),
    .i_data       (i_data),
    .i_stall      (i_stall),
    .o_valid      (o_valid),
    .o_data       (o_data),
    .cfg_wr       (cfg_wr),
    .cfg_data     (cfg_data),
    .cfg_pending  (cfg_pending),
    .o_cfg        (o_cfg),
    .cfg_apply_cnt(cfg_apply_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model state
  logic [N_PORTS-1:0] m_ov;
  logic [DATA_W-1:0]  m_od[N_PORTS];
  logic [N_PORTS-1:0] m_cfg;
  logic [N_PORTS-1:0] m_shadow;
  logic               m_pend;
  int                 m_cnt;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output p of a cell reads: bar -> itself, cross -> partner,
  // broadcast upper -> even port of the pair, broadcast lower -> odd port.
  function automatic int src_of(input int p, input logic [N_PORTS-1:0] cfg);
    int k;
    logic [1:0] m;
    k = p / 2;
    m = cfg[2*k +: 2];
    case (m)
      2'd0:    return p;
      2'd1:    return p ^ 1;
      2'd2:    return 2 * k;
      default: return 2 * k + 1;
    endcase
  endfunction

  function automatic logic [N_PORTS*DATA_W-1:0] exp_data();
    logic [N_PORTS*DATA_W-1:0] e;
    for (int p = 0; p < N_PORTS; p++) e[p*DATA_W +: DATA_W] = m_od[p];
    return e;
  endfunction

  task automatic compare_all(input string tag);
    chk({tag, ".o_valid"},     64'(o_valid),       64'(m_ov));
    chk({tag, ".o_data"},      64'(o_data),        64'(exp_data()));
    chk({tag, ".o_cfg"},       64'(o_cfg),         64'(m_cfg));
    chk({tag, ".cfg_pending"}, 64'(cfg_pending),   64'(m_pend));
    chk({tag, ".apply_cnt"},   64'(cfg_apply_cnt), 64'(m_cnt));
  endtask

  task automatic model_reset();
    m_ov = '0;
    for (int p = 0; p < N_PORTS; p++) m_od[p] = '0;
    m_cfg = '0; m_shadow = '0; m_pend = 1'b0; m_cnt = 0;
  endtask

  // driver tasks
  task automatic drive(input logic [N_PORTS-1:0] v, input logic [N_PORTS*DATA_W-1:0] d,
                       input logic st, input logic wr, input logic [N_PORTS-1:0] cd);
    i_valid = v; i_data = d; i_stall = st; cfg_wr = wr; cfg_data = cd;
  endtask

  // Advance one clock: predict from current inputs, then compare after the edge.
  task automatic step(input string tag);
    logic [N_PORTS-1:0] nv;
    logic [DATA_W-1:0]  nd[N_PORTS];
    bit                 ap;
    int                 s;
    nv = m_ov;
    for (int p = 0; p < N_PORTS; p++) nd[p] = m_od[p];
    if (!i_stall) begin
      for (int p = 0; p < N_PORTS; p++) begin
        s = src_of(p, m_cfg);
        nv[p] = i_valid[s];
        nd[p] = i_valid[s] ? i_data[s*DATA_W +: DATA_W] : '0;
      end
    end
    ap = m_pend && (i_valid == '0) && !i_stall;
    @(posedge clk);
    #1;
    m_ov = nv;
    for (int p = 0; p < N_PORTS; p++) m_od[p] = nd[p];
    if (ap) begin
      m_cfg = m_shadow;
      m_cnt = (m_cnt + 1) % 256;
    end
    if (cfg_wr) begin
      m_shadow = cfg_data;
      m_pend   = 1'b1;
    end else if (ap) begin
      m_pend = 1'b0;
    end
    compare_all(tag);
  endtask

  // Reset asserted away from any edge so its asynchronous effect is visible.
  task automatic pulse_reset(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all({tag, ".async"});
    drive('0, '0, 1'b0, 1'b0, '0);
    @(posedge clk);
    #1;
    compare_all({tag, ".held"});
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive('0, '0, 1'b0, 1'b0, '0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    chk("reset.lit_valid", 64'(o_valid), 64'h0);
    chk("reset.lit_cfg", 64'(o_cfg), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // identity under bar configuration
    drive(8'hFF, 32'h7654_3210, 1'b0, 1'b0, '0);
    step("bar");
    chk("bar.lit_data", 64'(o_data), 64'h7654_3210);
    chk("bar.lit_valid", 64'(o_valid), 64'hFF);

    // all-cross config written and applied while idle
    drive('0, '0, 1'b0, 1'b1, 8'b01_01_01_01);
    step("cross_wr");
    chk("cross_wr.lit_pend", 64'(cfg_pending), 64'h1);
    drive('0, '0, 1'b0, 1'b0, '0);
    step("cross_apply");
    chk("cross_apply.lit_cnt", 64'(cfg_apply_cnt), 64'h1);
    chk("cross_apply.lit_cfg", 64'(o_cfg), 64'h55);
    drive(8'hFF, 32'h7654_3210, 1'b0, 1'b0, '0);
    step("cross");
    chk("cross.lit_data", 64'(o_data), 64'h6745_2301);

    // broadcast modes
    drive('0, '0, 1'b0, 1'b1, 8'b11_10_11_10);
    step("bc_wr");
    drive('0, '0, 1'b0, 1'b0, '0);
    step("bc_apply");
    drive(8'b0000_0001, 32'hABCD_EF52, 1'b0, 1'b0, '0);
    step("bcast");
    chk("bcast.lit_valid", 64'(o_valid), 64'h03);
    chk("bcast.lit_data", 64'(o_data), 64'h22);

    // config write during continuous traffic waits for an idle cycle
    drive(8'h81, $urandom, 1'b0, 1'b1, 8'h55);
    step("traffic_wr");
    for (int i = 0; i < 5; i++) begin
      drive(8'($urandom_range(1, 255)), $urandom, 1'b0, 1'b0, '0);
      step("traffic");
    end
    chk("traffic.lit_pend", 64'(cfg_pending), 64'h1);
    chk("traffic.lit_cfg", 64'(o_cfg), 64'hEE);
    drive('0, $urandom, 1'b0, 1'b0, '0);
    step("traffic_idle");
    chk("traffic_idle.lit_cfg", 64'(o_cfg), 64'h55);
    chk("traffic_idle.lit_pend", 64'(cfg_pending), 64'h0);

    // stall freezes outputs; held inputs appear one cycle after release
    drive(8'hFF, 32'h7654_3210, 1'b0, 1'b0, '0);
    step("pre_stall");
    for (int i = 0; i < 3; i++) begin
      drive(8'hFF, 32'hFEDC_BA98, 1'b1, 1'b0, '0);
      step("stall");
      chk("stall.lit_data", 64'(o_data), 64'h6745_2301);
    end
    drive(8'hFF, 32'hFEDC_BA98, 1'b0, 1'b0, '0);
    step("release");
    chk("release.lit_data", 64'(o_data), 64'hEFCD_AB89);

    // reset while a config is pending
    drive(8'h0F, $urandom, 1'b0, 1'b1, 8'h9C);
    step("pend_before_rst");
    chk("pend_before_rst.lit", 64'(cfg_pending), 64'h1);
    pulse_reset("rst_pend");
    chk("rst_pend.lit_pend", 64'(cfg_pending), 64'h0);
    chk("rst_pend.lit_cfg", 64'(o_cfg), 64'h0);
    drive(8'hFF, 32'h7654_3210, 1'b0, 1'b0, '0);
    step("post_rst_bar");
    chk("post_rst_bar.lit_data", 64'(o_data), 64'h7654_3210);

    // 256 applications wrap the counter
    for (int i = 0; i < 256; i++) begin
      drive('0, '0, 1'b0, 1'b1, 8'($urandom));
      step("wrap");
    end
    chk("wrap.lit_255", 64'(cfg_apply_cnt), 64'd255);
    drive('0, '0, 1'b0, 1'b0, '0);
    step("wrap_last");
    chk("wrap.lit_0", 64'(cfg_apply_cnt), 64'd0);

    // random traffic, stalls and config writes
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom),
            $urandom,
            ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 4) == 0),
            8'($urandom));
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/benes_switch_column.md
BENES_SWITCH_COLUMN -- requirements
Module: benes_switch_column

Interface
REQ-001 Parameter DATA_W, default 4: bits per port.
REQ-002 Parameter N_PORTS, default 8: ports in the column; even, >= 2; column holds N_PORTS/2 2x2 cells.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_valid  input  N_PORTS  per-port input valid.
REQ-006 i_data  input  N_PORTS*DATA_W  per-port input data; port p occupies bits [p*DATA_W +: DATA_W].
REQ-007 i_stall  input  1  downstream stall; freezes the column.
REQ-008 o_valid  output  N_PORTS  per-port registered output valid.
REQ-009 o_data  output  N_PORTS*DATA_W  per-port registered output data, same packing as i_data.
REQ-010 cfg_wr  input  1  write strobe for the shadow configuration.
REQ-011 cfg_data  input  N_PORTS  shadow value; bits [2k+1:2k] are the mode of cell k.
REQ-012 cfg_pending  output  1  shadow written but not yet applied.
REQ-013 o_cfg  output  N_PORTS  active configuration.
REQ-014 cfg_apply_cnt  output  8  count of configuration applications; wraps at 255 -> 0.

Function
REQ-015 Cell k SHALL switch port pair (2k, 2k+1) by mode: 00 bar (0->0, 1->1), 01 cross (0->1, 1->0), 10 broadcast upper (0->both), 11 broadcast lower (1->both).
REQ-016 Latency SHALL be exactly 1 clk from i_valid/i_data to o_valid/o_data, using the active configuration of the sampling cycle.
REQ-017 o_valid[p] SHALL equal the i_valid of the source port selected for output p.
REQ-018 o_data[p] SHALL be 0 whenever o_valid[p] is 0.
REQ-019 While i_stall = 1, o_valid, o_data, o_cfg and cfg_apply_cnt SHALL hold, and inputs SHALL be ignored; upstream holds its data.
REQ-020 cfg_wr = 1 SHALL load cfg_data into the shadow and set cfg_pending on the next edge, regardless of i_stall.
REQ-021 An apply cycle is one with cfg_pending = 1, i_valid == 0 and i_stall = 0. On that edge, o_cfg SHALL take the shadow value, cfg_pending SHALL clear, and cfg_apply_cnt SHALL increment.
REQ-022 cfg_wr in an apply cycle: o_cfg SHALL take the pre-write shadow, the shadow SHALL take the new cfg_data, and cfg_pending SHALL remain 1.
REQ-023 cfg_wr while pending in a non-apply cycle SHALL overwrite the shadow; cfg_pending SHALL stay 1.
REQ-024 The active configuration SHALL never change in a cycle with any i_valid bit set; packets are never split across configurations.

Reset
REQ-025 While rst_n = 0, and immediately on its assertion (including mid-stall or mid-pending), the following SHALL reset: o_valid = 0, o_data = 0, o_cfg = 0 (all bar), shadow = 0, cfg_pending = 0, cfg_apply_cnt = 0.
REQ-026 The first input sampled after deassertion SHALL use the bar configuration.

Structure
REQ-027 Shared package benes_pkg SHALL hold the 2-bit cell-mode enum (BAR, CROSS, BCAST_UP, BCAST_LO) and the mode-field width constant.
REQ-028 Sub-module benes_sw_cell SHALL implement one 2x2 cell: mode, two valid/data inputs, two registered valid/data outputs, and stall; the column instantiates N_PORTS/2 of them via generate.
REQ-029 Configuration shadow, pending flag and apply counter SHALL live in benes_switch_column.

Verification (DATA_W = 4, N_PORTS = 8)
REQ-030 Reset then send i_valid = 8'hFF with port p carrying value p -> next cycle o_data ports = 0..7 in order, o_valid = 8'hFF.
REQ-031 Write cfg_data = 16'h... truncated to 8'b01_01_01_01 while idle -> apply one cycle later, cfg_apply_cnt = 1; then inputs 0..7 -> outputs 1,0,3,2,5,4,7,6.
REQ-032 Mode 8'b11_10_11_10 with i_valid = 8'b0000_0001 and port0 = 4'h2 -> o_valid = 8'b0000_0011, o_data ports 0/1 = 2, all others 0.
REQ-033 cfg_wr during continuous traffic -> o_cfg unchanged and cfg_pending = 1 until the first all-zero i_valid cycle, then applied.
REQ-034 i_stall = 1 for 3 cycles with new inputs -> outputs frozen; after release, held inputs appear 1 cycle later; rst_n pulse while pending -> cfg_pending = 0 and o_cfg = 0.
REQ-035 256 apply cycles -> cfg_apply_cnt wraps to 0.
